// File: rtl/grid_renderer_pkg.sv
// Shared grid geometry defaults, colour constants, renderer FSM encoding and the cell index helper.
package grid_renderer_pkg;

  localparam int         GRID_W_DEF    = 160;
  localparam int         GRID_H_DEF    = 120;
  localparam logic [2:0] FG_COLOUR_DEF = 3'b111;
  localparam logic [2:0] BG_COLOUR_DEF = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Column-major cell index; 15 bits covers the full 160x120 grid.
  function automatic logic [14:0] cell_idx(input logic [7:0] x, input logic [6:0] y,
                                           input int grid_h);
    return 15'(grid_h) * {7'd0, x} + {8'd0, y};
  endfunction

endpackage

// File: rtl/grid_renderer_if.sv
// Pixel write bus toward the VGA adapter: x/y/colour qualified by plot, accepted with draw_ready.
interface grid_renderer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       draw_ready;

  modport master (output x, y, colour, plot, input draw_ready);
  modport slave  (input x, y, colour, plot, output draw_ready);
endinterface

// File: rtl/grid_renderer_scan_counter.sv
// Column-major x/y scan counter; exposes next-cycle coordinates so colour can be fetched in the same edge.
module grid_scan_counter #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       advance,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [7:0] x_next,
  output logic [6:0] y_next,
  output logic       last
);

  localparam logic [7:0] X_MAX = 8'(GRID_W - 1);
  localparam logic [6:0] Y_MAX = 7'(GRID_H - 1);

  always_comb begin
    x_next = x;
    y_next = y;
    if (clear) begin
      x_next = '0;
      y_next = '0;
    end else if (advance) begin
      if (y == Y_MAX) begin
        y_next = '0;
        x_next = x + 8'd1;
      end else begin
        y_next = y + 7'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/grid_renderer.sv
// Scans the projectile grid column-major and emits one pixel write per cell with back-pressure.
// Optional GRID_SNAPSHOT_EN freezes the grid at LOAD so a frame never tears.
module grid_renderer
  import grid_renderer_pkg::*;
#(
  parameter int         GRID_W    = GRID_W_DEF,
  parameter int         GRID_H    = GRID_H_DEF,
  parameter logic [2:0] FG_COLOUR = FG_COLOUR_DEF,
  parameter logic [2:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [GRID_W*GRID_H-1:0] grid,
  grid_renderer_if.master          pix,
  output logic                     busy,
  output logic                     done
);

  state_t      state_q, state_d;
  logic        clear, advance, last, accept, colour_load, cell_bit;
  logic [7:0]  x_next;
  logic [6:0]  y_next;
  logic [14:0] idx;

  assign accept = pix.plot & pix.draw_ready;

  grid_scan_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .advance (advance),
    .x       (pix.x),
    .y       (pix.y),
    .x_next  (x_next),
    .y_next  (y_next),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        clear   = 1'b1;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (accept) begin
          // The final cell holds its coordinate; the frame never wraps back to (0,0).
          if (last) state_d = ST_DONE;
          else      advance = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign idx         = cell_idx(x_next, y_next, GRID_H);
  assign colour_load = (state_q == ST_LOAD) || advance;

`ifdef GRID_SNAPSHOT_EN
  logic [GRID_W*GRID_H-1:0] snap;

  always_ff @(posedge clock) begin
    if (state_q == ST_LOAD) snap <= grid;
  end

  // Pixel (0,0) is fetched in the same edge the copy is taken, so it reads the live bus.
  assign cell_bit = (state_q == ST_LOAD) ? grid[idx] : snap[idx];
`else
  assign cell_bit = grid[idx];
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pix.plot   <= 1'b0;
      pix.colour <= BG_COLOUR;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix.plot <= (state_d == ST_DRAW);
      busy     <= (state_d == ST_LOAD) || (state_d == ST_DRAW);
      done     <= (state_d == ST_DONE);
      if (colour_load) pix.colour <= cell_bit ? FG_COLOUR : BG_COLOUR;
    end
  end

endmodule
